// File: rtl/dpram_asym_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_asym_pkg
//  Description : Shared definitions for the asymmetric dual-port RAM:
//                clear-FSM state encoding and a constant-foldable clog2.
//  Revision    : 1.0 - initial release
// ============================================================================
package dpram_asym_pkg;

    // Clear sequencer states.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Ceiling log2, usable in parameter/localparam expressions.
    // clog2(1) = 0, clog2(2) = 1, clog2(64) = 6.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_asym_clr.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_asym_clr
//  Description : Clear sequencer. Sweeps every write address once, writing
//                zero, after reset and on a clr request while idle.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset (forces CLEAR, cnt=0)
//                clr   - start-clear request, level-sampled in IDLE
//                busy  - high exactly while a clear sweep is in progress
//                cnt   - address being cleared this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_asym_clr
    import dpram_asym_pkg::*;
#(
    parameter int   WDEPTH = 64,
    localparam int  AW     = clog2(WDEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    output logic [AW-1:0] cnt
);

    localparam logic [AW-1:0] c_last_addr = AW'(WDEPTH - 1);

    clr_state_t    r_state;
    clr_state_t    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter wraps naturally to 0 on the final sweep edge, so the next
    // clear always starts at address 0 without an explicit reload.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (clr) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_last_addr) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    assign busy = (r_state == CLEAR);
    assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/dpram_asym.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_asym
//  Description : Asymmetric dual-port RAM. Narrow (WW) write port, wide
//                (WW*RATIO) registered read port, self-clearing after reset
//                or on request.
//  Ports       : clk, rst_n      - clock / asynchronous active-low reset
//                we, wa, wd      - write strobe, address, data (narrow)
//                re, ra          - read enable, read word address (wide)
//                rd, rvalid      - registered read data, one-cycle valid
//                clr, busy       - clear request, clear in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_asym
    import dpram_asym_pkg::*;
#(
    parameter int   WW      = 8,
    parameter int   RATIO   = 2,
    parameter int   WDEPTH  = 64,
    parameter int   BIG_END = 0,
    parameter int   BYPASS  = 0,
    localparam int  AW      = clog2(WDEPTH),
    localparam int  LW      = clog2(RATIO),
    localparam int  RW      = WW * RATIO,
    localparam int  RAW     = AW - LW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [AW-1:0]  wa,
    input  logic [WW-1:0]  wd,
    input  logic           re,
    input  logic [RAW-1:0] ra,
    output logic [RW-1:0]  rd,
    output logic           rvalid,
    input  logic           clr,
    output logic           busy
);

    localparam int c_lane_depth = WDEPTH / RATIO;

    logic           w_busy;
    logic [AW-1:0]  w_cnt;
    logic           w_wen;
    logic [AW-1:0]  w_waddr;
    logic [WW-1:0]  w_wdata;
    logic [RAW-1:0] w_wrow;
    logic [AW-1:0]  w_wlane;
    logic           w_rd_acc;
    logic           r_rvalid;

    dpram_asym_clr #(
        .WDEPTH (WDEPTH)
    ) u_clr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .busy   (w_busy),
        .cnt    (w_cnt)
    );

    // One physical write port per lane, shared by the clear sweep and the
    // user. During a sweep the user strobe is ignored entirely.
    assign w_wen    = w_busy | we;
    assign w_waddr  = w_busy ? w_cnt : wa;
    assign w_wdata  = w_busy ? '0 : wd;

    // Low address bits select the lane array, high bits the row within it.
    assign w_wrow   = RAW'(w_waddr >> LW);
    assign w_wlane  = w_waddr & AW'(RATIO - 1);

    assign w_rd_acc = re & ~w_busy;

    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        // Output lane driven by write location ra*RATIO+k.
        localparam int c_pos = (BIG_END != 0) ? (RATIO - 1 - k) : k;

        logic [WW-1:0] r_mem [c_lane_depth];
        logic [WW-1:0] r_q;
        logic          w_hit;

        assign w_hit = w_wen && (w_wlane == AW'(k));

        // Storage has no reset so it maps onto block RAM.
        always_ff @(posedge clk) begin
            if (w_hit) begin
                r_mem[w_wrow] <= w_wdata;
            end
        end

        // Read-before-write: a same-edge write to this lane returns the old
        // word unless forwarding is enabled. A read is only accepted while
        // idle, so w_hit here always means a user write.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_rd_acc) begin
                if ((BYPASS != 0) && w_hit && (w_wrow == ra)) begin
                    r_q <= wd;
                end else begin
                    r_q <= r_mem[ra];
                end
            end
        end

        assign rd[c_pos*WW +: WW] = r_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_acc;
        end
    end

    assign rvalid = r_rvalid;
    assign busy   = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_dpram_asym.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpram_asym
//  Description : Self-checking bench for dpram_asym. Two instances share the
//                write/clear stimulus: u_dut0 (RATIO=2, little-endian, no
//                forwarding) and u_dut1 (RATIO=4, big-endian, forwarding).
//                A flat byte-array reference model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_asym;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic        clr   = 1'b0;
    logic [5:0]  wa    = '0;
    logic [7:0]  wd    = '0;
    logic [4:0]  ra0   = '0;
    logic [3:0]  ra1   = '0;
    logic [15:0] rd0;
    logic [31:0] rd1;
    logic        rv0, rv1, busy0, busy1;

    always #5 clk = ~clk;

    dpram_asym #(.WW(8), .RATIO(2), .WDEPTH(64), .BIG_END(0), .BYPASS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra0),
        .rd(rd0), .rvalid(rv0), .clr(clr), .busy(busy0)
    );

    dpram_asym #(.WW(8), .RATIO(4), .WDEPTH(64), .BIG_END(1), .BYPASS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra1),
        .rd(rd1), .rvalid(rv1), .clr(clr), .busy(busy1)
    );

    // Reference model state
    logic [7:0]  m_mem [64];
    int          m_left;      // remaining clear cycles; 0 means idle
    logic [15:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_rv;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wide word as seen at the read port, from the flat memory image.
    function automatic logic [31:0] model_word(input int ratio, input int be,
                                               input int byp, input int addr);
        logic [31:0] w;
        logic [7:0]  d;
        int          loc;
        int          lane;
        w = '0;
        for (int k = 0; k < ratio; k++) begin
            loc = addr * ratio + k;
            d   = m_mem[loc];
            if (byp != 0 && we && m_left == 0 && int'(wa) == loc) d = wd;
            lane = (be != 0) ? (ratio - 1 - k) : k;
            w[lane*8 +: 8] = d;
        end
        return w;
    endfunction

    task automatic model_clear_mem();
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    endtask

    // Advance one clock with the currently driven inputs, then compare.
    task automatic step();
        logic        acc;
        logic [31:0] t;
        acc = (m_left == 0);
        e_rv = acc && re;
        if (e_rv) begin
            t     = model_word(2, 0, 0, int'(ra0));
            e_rd0 = t[15:0];
            e_rd1 = model_word(4, 1, 1, int'(ra1));
        end
        if (acc && we) m_mem[wa] = wd;
        if (m_left > 0) begin
            m_left--;
        end else if (clr) begin
            m_left = 64;
            model_clear_mem();
        end
        @(posedge clk);
        #1;
        chk("busy0", busy0, (m_left != 0));
        chk("busy1", busy1, (m_left != 0));
        chk("rvalid0", rv0, e_rv);
        chk("rvalid1", rv1, e_rv);
        chk("rd0", rd0, e_rd0);
        chk("rd1", rd1, e_rd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_rv0", rv0, 32'h0);
        chk("rst_rv1", rv1, 32'h0);
        chk("rst_busy0", busy0, 32'h1);
        chk("rst_busy1", busy1, 32'h1);
        m_left = 64;
        e_rd0  = '0;
        e_rd1  = '0;
        e_rv   = 1'b0;
        model_clear_mem();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        we = 1'b1; wa = a; wd = d; re = 1'b0;
        step();
        we = 1'b0;
    endtask

    task automatic rd_both(input logic [4:0] a0, input logic [3:0] a1);
        re = 1'b1; ra0 = a0; ra1 = a1;
        step();
        re = 1'b0;
    endtask

    task automatic idle(input int n);
        we = 1'b0; re = 1'b0; clr = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_both(5'(i), 4'(i));
            chk(tag, rd0, 32'h0);
            chk(tag, rd1, 32'h0);
        end
        idle(1);
    endtask

    initial begin
        m_left = 0;
        e_rd0  = '0;
        e_rd1  = '0;
        e_rv   = 1'b0;
        model_clear_mem();

        // Power-on clear, then every word reads back zero.
        reset_pulse();
        idle(63);
        chk("busy_c63", busy0, 32'h1);
        idle(1);
        chk("busy_c64", busy0, 32'h0);
        read_all_zero("zero_after_rst");

        // Lane ordering.
        wr(6'd0, 8'h05);
        wr(6'd1, 8'h06);
        wr(6'd2, 8'h07);
        rd_both(5'd0, 4'd0);
        chk("le_ra0", rd0, 32'h0605);
        chk("be4_ra0", rd1, 32'h05060700);
        chk("pulse_on", rv0, 32'h1);
        rd_both(5'd1, 4'd0);
        chk("le_ra1", rd0, 32'h0007);
        idle(1);
        chk("pulse_off", rv0, 32'h0);
        chk("hold_rd0", rd0, 32'h0007);

        // Same-edge write/read: old data without forwarding, new with it.
        wr(6'd4, 8'hAA);
        we = 1'b1; wa = 6'd4; wd = 8'h55; re = 1'b1; ra0 = 5'd2; ra1 = 4'd1;
        step();
        we = 1'b0; re = 1'b0;
        chk("nobyp_lane", rd0, 32'h00AA);
        chk("byp_lane", rd1, 32'h55000000);

        // Four-lane word.
        wr(6'd0, 8'h11);
        wr(6'd1, 8'h22);
        wr(6'd2, 8'h33);
        wr(6'd3, 8'h44);
        rd_both(5'd1, 4'd0);
        chk("r4_word", rd1, 32'h11223344);
        chk("r2_word", rd0, 32'h4433);

        // Random traffic with occasional clear requests.
        for (int i = 0; i < 500; i++) begin
            we  = 1'($urandom_range(0, 1));
            re  = 1'($urandom_range(0, 1));
            wa  = 6'($urandom_range(0, 63));
            wd  = 8'($urandom);
            ra0 = 5'($urandom_range(0, 31));
            ra1 = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 99) == 0);
            step();
        end
        idle(64);

        // Clear with ignored traffic, interrupted by reset at cycle 20.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 19; i++) begin
            we  = 1'($urandom_range(0, 1));
            re  = 1'($urandom_range(0, 1));
            wa  = 6'($urandom_range(0, 63));
            wd  = 8'($urandom);
            ra0 = 5'($urandom_range(0, 31));
            ra1 = 4'($urandom_range(0, 15));
            clr = 1'($urandom_range(0, 1));
            step();
        end
        clr = 1'b0;
        reset_pulse();
        for (int i = 0; i < 64; i++) begin
            we  = 1'b1;
            re  = 1'b1;
            wa  = 6'($urandom_range(0, 63));
            wd  = 8'($urandom_range(1, 255));
            ra0 = 5'($urandom_range(0, 31));
            ra1 = 4'($urandom_range(0, 15));
            step();
        end
        we = 1'b0; re = 1'b0;
        chk("busy_end", busy0, 32'h0);
        read_all_zero("zero_after_clr");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpram_asym.md
DPRAM_ASYM -- requirements
Module: dpram_asym

Interface
REQ-001 The block SHALL have parameter WW, default 8, meaning write-port width in bits.
REQ-002 The block SHALL have parameter RATIO, default 2, meaning write words per read word; legal values are 1, 2, 4 and 8.
REQ-003 The block SHALL have parameter WDEPTH, default 64, meaning depth in write words; it SHALL be a power of 2 and a multiple of RATIO.
REQ-004 The block SHALL have parameter BIG_END, default 0, meaning lane order: 0 puts the lowest write address in rd[WW-1:0], 1 puts it in the top lane.
REQ-005 The block SHALL have parameter BYPASS, default 0, meaning same-cycle write data forwards to the read port when 1.
REQ-006 Ports, with AW = clog2(WDEPTH), RW = WW*RATIO and RAW = AW - clog2(RATIO):
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write strobe
- wa  in  AW  write address
- wd  in  WW  write data
- re  in  1  read enable
- ra  in  RAW  read word address
- rd  out  RW  registered read data
- rvalid  out  1  rd updated this cycle
- clr  in  1  start-clear request, level-sampled
- busy  out  1  clear in progress

Function
REQ-007 A write with we=1, busy=0 and a rising clk edge SHALL store wd at location wa.
REQ-008 Read word ra SHALL consist of write locations ra*RATIO+k, with k running from 0 to RATIO-1.
REQ-009 Location ra*RATIO+k SHALL drive lane k when BIG_END=0, and lane RATIO-1-k when BIG_END=1.
REQ-010 re=1 with busy=0 at edge N SHALL load rd at edge N and SHALL set rvalid=1 for exactly the following cycle.
REQ-011 rd SHALL hold its value whenever no read is accepted.
REQ-012 When a write and a read of the same word occur on the same edge, the written lane SHALL return the old data if BYPASS=0 and the new wd if BYPASS=1; other lanes SHALL be unaffected.
REQ-013 The clear FSM SHALL have two states, IDLE and CLEAR.
REQ-014 IDLE SHALL go to CLEAR when clr=1.
REQ-015 In CLEAR, the FSM SHALL write 0 to address cnt and increment cnt each cycle, where cnt is an AW-bit counter.
REQ-016 CLEAR SHALL go to IDLE on the edge that writes address WDEPTH-1; cnt SHALL then wrap to 0.
REQ-017 busy SHALL be 1 exactly while the state is CLEAR; a clear SHALL last WDEPTH cycles.
REQ-018 While busy=1, we and re SHALL be ignored, and rvalid SHALL stay 0.
REQ-019 clr asserted while busy=1 SHALL be ignored, with no restart and no extension.
REQ-020 clr and we on the same edge in IDLE SHALL commit the write, and the clear SHALL overwrite it later.
REQ-021 Out-of-range addresses cannot occur because widths are exact; address wrap is natural.

Reset
REQ-022 Assertion of rst_n=0 SHALL asynchronously force rd=0, rvalid=0 and cnt=0, and SHALL put the FSM in CLEAR so that busy=1.
REQ-023 After rst_n deasserts, the FSM SHALL clear all WDEPTH locations before accepting any access.
REQ-024 Reset asserted mid-clear or mid-read SHALL restart the clear from address 0.
REQ-025 RAM contents SHALL NOT be reset asynchronously, and the storage array SHALL carry no reset so that it infers block RAM.

Structure
REQ-026 Package dpram_asym_pkg SHALL hold the FSM state encoding (IDLE=1'b0, CLEAR=1'b1) and the clog2 helper function.
REQ-027 Sub-module dpram_asym_clr (FSM, cnt, busy) SHALL be the only sub-module.
REQ-028 Storage SHALL be RATIO lane arrays, each WDEPTH/RATIO by WW, so that the wide read takes one access per lane.

Verification
All scenarios use WW=8, RATIO=2, WDEPTH=64 unless noted.
REQ-029 Reset, then wait 64 cycles: busy falls on cycle 64, and a read of each of ra=0..31 returns 16'h0000.
REQ-030 Write wa=0,1,2 with 8'h05,06,07, then read ra=0 and ra=1: rd=16'h0605 then 16'h0007, each with a 1-cycle rvalid pulse.
REQ-031 With BIG_END=1 and the REQ-030 writes, ra=0: rd=16'h0506.
REQ-032 Preload 8'hAA at wa=4, then write wa=4 with 8'h55 and read ra=2 on the same edge: rd[7:0]=8'hAA with BYPASS=0, and 8'h55 with BYPASS=1.
REQ-033 With RATIO=4 and WW=8, write wa=0..3 with 8'h11,22,33,44, then read ra=0: rd=32'h44332211.
REQ-034 Pulse clr, attempt we/re during busy, then pulse rst_n low at cycle 20: no rvalid occurs, busy stays high for 64 cycles after reset release, and all data reads back 0.
